// File: rtl/jellyvl_stream_rr_arbiter.sv
// Round-robin packet arbiter: N valid/ready requesters share one registered output stream.
// A grant is held until the granted requester's last beat is accepted.
module jellyvl_stream_rr_arbiter #(
   parameter int unsigned N         = 4,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned ID_BITS   = (N > 1) ? $clog2(N) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cke,

   input  logic [N*DATA_BITS-1:0] s_data,
   input  logic [N-1:0]           s_last,
   input  logic [N-1:0]           s_valid,
   output logic [N-1:0]           s_ready,

   output logic [DATA_BITS-1:0]   m_data,
   output logic                   m_last,
   output logic [ID_BITS-1:0]     m_id,
   output logic                   m_valid,
   input  logic                   m_ready
);

   typedef enum logic [0:0] {StIdle, StBusy} state_t;

   state_t               state_q, state_d;
   logic [ID_BITS-1:0]   grant_q, grant_d;
   logic [ID_BITS-1:0]   prev_q, prev_d;
   logic [DATA_BITS-1:0] m_data_q, m_data_d;
   logic                 m_last_q, m_last_d;
   logic [ID_BITS-1:0]   m_id_q, m_id_d;
   logic                 m_valid_q, m_valid_d;

   logic [DATA_BITS-1:0] s_data_lane [N];
   logic                 out_free;
   logic                 s_xfer;
   logic                 search_found;
   logic [ID_BITS-1:0]   search_idx;

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign s_data_lane[i] = s_data[i*DATA_BITS +: DATA_BITS];
   end

   // Output register can take a beat when empty or being drained this cycle.
   assign out_free = !m_valid_q || m_ready;

   always_comb begin
      s_ready = '0;
      if (state_q == StBusy && cke && out_free) begin
         s_ready[grant_q] = 1'b1;
      end
   end

   assign s_xfer = s_valid[grant_q] && s_ready[grant_q];

   // Rotating priority search starting just after the last granted requester.
   always_comb begin
      int unsigned        idx_wide;
      logic [ID_BITS-1:0] idx;
      search_found = 1'b0;
      search_idx   = '0;
      idx_wide     = 0;
      idx          = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx_wide = (32'(prev_q) + k) % N;
         idx      = ID_BITS'(idx_wide);
         if (!search_found && s_valid[idx]) begin
            search_found = 1'b1;
            search_idx   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      prev_d    = prev_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      m_id_d    = m_id_q;
      m_valid_d = m_valid_q;

      if (cke) begin
         case (state_q)
            StIdle: begin
               if (search_found) begin
                  grant_d = search_idx;
                  prev_d  = search_idx;
                  state_d = StBusy;
               end
            end
            StBusy: begin
               if (s_xfer && s_last[grant_q]) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase

         if (s_xfer) begin
            m_data_d  = s_data_lane[grant_q];
            m_last_d  = s_last[grant_q];
            m_id_d    = grant_q;
            m_valid_d = 1'b1;
         end else if (m_ready) begin
            m_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         prev_q    <= ID_BITS'(N - 1);
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_id_q    <= '0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         prev_q    <= prev_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_id_q    <= m_id_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign m_id    = m_id_q;
   assign m_valid = m_valid_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert ($onehot0(s_ready));
      end
   end

endmodule
